// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// word geometry, default address width and the frame count check.
package imem_loader_pkg;

    localparam int WORD_BYTES     = 4;
    localparam int DEFAULT_ADDR_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // A frame must carry at least one word and no more than the memory holds.
    function automatic logic count_legal(input logic [7:0] n, input int depth);
        return (n != 8'd0) && (int'(n) <= depth);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word assembler with a running XOR over every byte seen
// since the last clear; clear also seeds the XOR with the byte on din.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        shift,
    input  logic        clear,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        wordFull,
    output logic [7:0]  xorSum
);

    logic [23:0] shreg;
    logic [1:0]  byte_cnt;

    // The fourth byte never needs storing: the word is presented with din appended.
    assign word     = {shreg, din};
    assign wordFull = shift && (byte_cnt == 2'(WORD_BYTES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            byte_cnt <= '0;
            xorSum   <= '0;
        end else if (clear) begin
            shreg    <= '0;
            byte_cnt <= '0;
            xorSum   <= din;
        end else if (shift) begin
            shreg    <= {shreg[15:0], din};
            byte_cnt <= byte_cnt + 2'd1;
            xorSum   <= xorSum ^ din;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: consumes COUNT/DATA/CHK frames, writes words
// sequentially and holds the core in reset until a checksum-verified load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byteValid,
    input  logic [7:0]        byteData,
    output logic              byteReady,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [31:0]       wrData,
    output logic              cpuHold,
    output logic              done,
    output logic              error
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int IDX_W = ADDR_W + 1;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] word_cnt;
    logic             xfer;
    logic             shift;
    logic             clear;
    logic             last_word;
    logic [31:0]      word;
    logic             word_full;
    logic [7:0]       xor_sum;

    assign xfer      = byteValid && byteReady;
    assign shift     = xfer && (state == ST_DATA);
    assign clear     = xfer && (state == ST_COUNT);
    assign last_word = (word_idx + IDX_W'(1)) == word_cnt;

    imem_word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .shift    (shift),
        .clear    (clear),
        .din      (byteData),
        .word     (word),
        .wordFull (word_full),
        .xorSum   (xor_sum)
    );

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        byteReady  = 1'b0;
        cpuHold    = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_COUNT;
            end
            ST_COUNT: begin
                byteReady = 1'b1;
                cpuHold   = 1'b1;
                if (xfer) state_next = count_legal(byteData, DEPTH) ? ST_DATA : ST_ERR;
            end
            ST_DATA: begin
                // The write cycle stalls the stream so the word register is free again.
                byteReady = !wrEn;
                cpuHold   = 1'b1;
                if (wrEn && last_word) state_next = ST_CHK;
            end
            ST_CHK: begin
                byteReady = 1'b1;
                cpuHold   = 1'b1;
                if (xfer) state_next = (byteData == xor_sum) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_next = ST_COUNT;
            end
            ST_ERR: begin
                error   = 1'b1;
                cpuHold = 1'b1;
                if (start) state_next = ST_COUNT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wrEn     <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
            word_idx <= '0;
            word_cnt <= '0;
        end else begin
            state <= state_next;
            wrEn  <= word_full;
            if (word_full) begin
                wrAddr <= word_idx[ADDR_W-1:0];
                wrData <= word;
            end
            if (clear) begin
                word_cnt <= IDX_W'(byteData);
                word_idx <= '0;
            end else if (wrEn) begin
                word_idx <= word_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed frames push expected writes,
// an independent monitor pops and compares every write strobe.
module tb_imem_loader;

    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              byteValid;
    logic [7:0]        byteData;
    logic              byteReady;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [31:0]       wrData;
    logic              cpuHold;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .byteValid (byteValid),
        .byteData  (byteData),
        .byteReady (byteReady),
        .wrEn      (wrEn),
        .wrAddr    (wrAddr),
        .wrData    (wrData),
        .cpuHold   (cpuHold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t sb[$];
    wr_t exp_wr;
    int  checks   = 0;
    int  failures = 0;
    int  edges    = 0;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wrEn === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h@%h required=no_write", wrData, wrAddr);
            end else begin
                exp_wr = sb.pop_front();
                check("wr_addr", 32'(wrAddr), 32'(exp_wr.addr));
                check("wr_data", wrData, exp_wr.data);
                check("ready_in_write", 32'(byteReady), 32'd0);
            end
        end
    end

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        sb.push_back('{addr: a, data: d});
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                byteValid = 1'b0;
                @(negedge clk);
            end
        end
        byteValid = 1'b1;
        byteData  = b;
        guard     = 0;
        while (!byteReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!byteReady) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=no_ready required=ready byte=%h", b);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        byteValid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit gaps);
        foreach (f[i]) send_byte(f[i], gaps);
    endtask

    task automatic do_start();
        byteValid = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(byteReady), 32'd0);
        check({tag, "_wren"},  32'(wrEn),      32'd0);
        check({tag, "_addr"},  32'(wrAddr),    32'd0);
        check({tag, "_data"},  wrData,         32'd0);
        check({tag, "_hold"},  32'(cpuHold),   32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_error"}, 32'(error),     32'd0);
    endtask

    logic [7:0] good_f[$];
    logic [7:0] bad_f[$];
    logic [7:0] part_f[$];
    logic [7:0] beef_f[$];
    int         t0;

    initial begin
        good_f = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h20, 8'h3C};
        bad_f  = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h20, 8'h3D};
        part_f = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22};
        beef_f = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};

        rst = 1'b1; start = 1'b0; byteValid = 1'b0; byteData = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset with random inputs present, then idle without start.
        rst = 1'b1; start = 1'($urandom); byteValid = 1'($urandom); byteData = 8'($urandom);
        @(negedge clk);
        check_reset_values("rst");
        rst = 1'b0; start = 1'b0; byteValid = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_ready", 32'(byteReady), 32'd0);
        check("idle_hold",  32'(cpuHold),   32'd0);

        // Good load with continuous valid; frame is 1 + 5*2 + 1 edges long.
        push_wr(5'd0, 32'h20010005);
        push_wr(5'd1, 32'h00221820);
        do_start();
        t0 = edges;
        check("count_ready", 32'(byteReady), 32'd1);
        check("count_hold",  32'(cpuHold),   32'd1);
        send_frame(good_f, 1'b0);
        check("good_len",   32'(edges - t0), 32'd12);
        check("good_done",  32'(done),       32'd1);
        check("good_error", 32'(error),      32'd0);
        check("good_hold",  32'(cpuHold),    32'd0);
        check("good_ready", 32'(byteReady),  32'd0);
        check("good_sb",    32'(sb.size()),  32'd0);

        // Bad checksum: writes stand, core stays held; a retry recovers.
        push_wr(5'd0, 32'h20010005);
        push_wr(5'd1, 32'h00221820);
        do_start();
        check("restart_done_clr", 32'(done), 32'd0);
        send_frame(bad_f, 1'b0);
        check("bad_error", 32'(error),      32'd1);
        check("bad_done",  32'(done),       32'd0);
        check("bad_hold",  32'(cpuHold),    32'd1);
        check("bad_sb",    32'(sb.size()),  32'd0);
        push_wr(5'd0, 32'h20010005);
        push_wr(5'd1, 32'h00221820);
        do_start();
        check("retry_error_clr", 32'(error), 32'd0);
        send_frame(good_f, 1'b0);
        check("retry_done", 32'(done),      32'd1);
        check("retry_sb",   32'(sb.size()), 32'd0);

        // Illegal counts: zero and DEPTH+1.
        do_start();
        send_byte(8'h00, 1'b0);
        check("cnt0_error", 32'(error),     32'd1);
        check("cnt0_hold",  32'(cpuHold),   32'd1);
        check("cnt0_ready", 32'(byteReady), 32'd0);
        do_start();
        check("cnt_err_clr", 32'(error), 32'd0);
        send_byte(8'h21, 1'b0);
        check("cnt33_error", 32'(error), 32'd1);
        check("cnt33_done",  32'(done),  32'd0);
        repeat (5) @(negedge clk);

        // Backpressure: valid drops at random, bytes held across write cycles.
        push_wr(5'd0, 32'h20010005);
        push_wr(5'd1, 32'h00221820);
        do_start();
        send_frame(good_f, 1'b1);
        check("bp_done", 32'(done),      32'd1);
        check("bp_sb",   32'(sb.size()), 32'd0);

        // Reset after six data bytes, then a one-word load.
        push_wr(5'd0, 32'h20010005);
        do_start();
        send_frame(part_f, 1'b0);
        check("part_sb", 32'(sb.size()), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        push_wr(5'd0, 32'hDEADBEEF);
        do_start();
        send_frame(beef_f, 1'b0);
        check("beef_done",  32'(done),      32'd1);
        check("beef_hold",  32'(cpuHold),   32'd0);
        check("beef_sb",    32'(sb.size()), 32'd0);
        check("beef_wdata", wrData,         32'hDEADBEEF);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
